// File: rtl/orv_lsu_pkg.sv
// Shared definitions for the load/store unit: access lengths, writeback
// select, exception codes, FSM states and the store lane helpers.
package orv_lsu_pkg;

    localparam logic [1:0] L8    = 2'b00;
    localparam logic [1:0] L16   = 2'b01;
    localparam logic [1:0] L32   = 2'b10;
    localparam logic [1:0] L_ILL = 2'b11;

    localparam logic [2:0] REG_LOAD = 3'b001;

    localparam logic [1:0] NO_EXCEP   = 2'b00;
    localparam logic [1:0] INST_EXCEP = 2'b01;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_REQ  = 2'b01,
        LSU_WAIT = 2'b10
    } lsu_state_e;

    // Exactly one of load/store, a defined length, and natural alignment.
    function automatic logic lsu_legal(input logic ld, input logic st,
                                       input logic [1:0] len, input logic [1:0] addr_lo);
        logic aligned;
        case (len)
            L8:      aligned = 1'b1;
            L16:     aligned = ~addr_lo[0];
            L32:     aligned = (addr_lo == 2'b00);
            default: aligned = 1'b0;
        endcase
        return aligned & (ld ^ st);
    endfunction

    // Byte enables for the lanes touched by the access.
    function automatic logic [3:0] lsu_be(input logic [1:0] len, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (len)
            L8:      be = 4'b0001 << addr_lo;
            L16:     be = 4'b0011 << {addr_lo[1], 1'b0};
            L32:     be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate right-justified store data into every lane it may occupy.
    function automatic logic [31:0] lsu_wdata(input logic [1:0] len, input logic [31:0] wdata);
        logic [31:0] wd;
        case (len)
            L8:      wd = {4{wdata[7:0]}};
            L16:     wd = {2{wdata[15:0]}};
            L32:     wd = wdata;
            default: wd = 32'h0000_0000;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/orv_lsu_if.sv
// Data-memory request/grant/response port between the LSU and memory.
interface orv_lsu_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic          req;
    logic          gnt;
    logic          we;
    logic [3:0]    be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/orv_lsu_fmt.sv
// Load data formatter: picks the addressed byte/half out of the returned
// word and sign- or zero-extends it to 32 bits.
module orv_lsu_fmt
    import orv_lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  len,
    input  logic        uns,
    output logic [31:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection from the low address bits.
    always_comb begin
        byte_s = 8'h00;
        case (addr_lo)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            2'b11:   byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_lo[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
    end

    // Extension to full width according to length and signedness.
    always_comb begin
        data = 32'h0000_0000;
        case (len)
            L8:      data = {{24{~uns & byte_s[7]}}, byte_s};
            L16:     data = {{16{~uns & half_s[15]}}, half_s};
            L32:     data = rdata;
            default: data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/orv_lsu.sv
// Load/store unit: accepts one memory op from EX, runs it over the
// req/gnt/rvalid port, stalls the pipeline meanwhile and returns load data.
module orv_lsu
    import orv_lsu_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ex_valid_i,
    input  logic          ex_load_i,
    input  logic          ex_store_i,
    input  logic [1:0]    ex_len_i,
    input  logic          ex_unsigned_i,
    input  logic [AW-1:0] ex_addr_i,
    input  logic [DW-1:0] ex_wdata_i,
    input  logic [4:0]    ex_rd_i,
    input  logic          flush_i,
    output logic          lsu_busy_o,
    orv_lsu_if.master     dmem,
    output logic          wb_valid_o,
    output logic [4:0]    wb_rd_o,
    output logic [DW-1:0] wb_data_o,
    output logic [2:0]    wb_sel_o,
    output logic [1:0]    excep_o
);

    lsu_state_e    state_r;
    logic          req_r;
    logic          we_r;
    logic [3:0]    be_r;
    logic [AW-1:0] addr_r;
    logic [DW-1:0] wdata_r;
    logic          op_load_r;
    logic [1:0]    op_len_r;
    logic          op_uns_r;
    logic [1:0]    op_lo_r;
    logic [4:0]    op_rd_r;
    logic          dropped_r;
    logic          wb_valid_r;
    logic [4:0]    wb_rd_r;
    logic [DW-1:0] wb_data_r;
    logic [1:0]    excep_r;

    logic          op_s;
    logic          legal_s;
    logic          accept_s;
    logic          illegal_s;
    logic [DW-1:0] fmt_data_s;

    // Decode of the op offered by EX while idle and not flushed.
    always_comb begin
        op_s      = ex_valid_i & ~flush_i & (state_r == LSU_IDLE);
        legal_s   = lsu_legal(ex_load_i, ex_store_i, ex_len_i, ex_addr_i[1:0]);
        accept_s  = op_s & legal_s;
        illegal_s = op_s & (ex_load_i | ex_store_i) & ~legal_s;
    end

    orv_lsu_fmt u_fmt (
        .rdata   (dmem.rdata),
        .addr_lo (op_lo_r),
        .len     (op_len_r),
        .uns     (op_uns_r),
        .data    (fmt_data_s)
    );

    // Main FSM with all bus, writeback and exception outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= LSU_IDLE;
            req_r      <= 1'b0;
            we_r       <= 1'b0;
            be_r       <= 4'b0000;
            addr_r     <= '0;
            wdata_r    <= '0;
            op_load_r  <= 1'b0;
            op_len_r   <= 2'b00;
            op_uns_r   <= 1'b0;
            op_lo_r    <= 2'b00;
            op_rd_r    <= 5'd0;
            dropped_r  <= 1'b0;
            wb_valid_r <= 1'b0;
            wb_rd_r    <= 5'd0;
            wb_data_r  <= '0;
            excep_r    <= NO_EXCEP;
        end else begin
            wb_valid_r <= 1'b0;
            excep_r    <= NO_EXCEP;
            case (state_r)
                LSU_IDLE: begin
                    if (accept_s) begin
                        state_r   <= LSU_REQ;
                        req_r     <= 1'b1;
                        we_r      <= ex_store_i;
                        be_r      <= lsu_be(ex_len_i, ex_addr_i[1:0]);
                        addr_r    <= {ex_addr_i[AW-1:2], 2'b00};
                        wdata_r   <= lsu_wdata(ex_len_i, ex_wdata_i);
                        op_load_r <= ex_load_i;
                        op_len_r  <= ex_len_i;
                        op_uns_r  <= ex_unsigned_i;
                        op_lo_r   <= ex_addr_i[1:0];
                        op_rd_r   <= ex_rd_i;
                        dropped_r <= 1'b0;
                    end else if (illegal_s) begin
                        excep_r <= INST_EXCEP;
                    end
                end
                LSU_REQ: begin
                    if (dmem.gnt) begin
                        state_r <= LSU_WAIT;
                        req_r   <= 1'b0;
                        if (flush_i) begin
                            dropped_r <= 1'b1;
                        end
                    end else if (flush_i) begin
                        state_r <= LSU_IDLE;
                        req_r   <= 1'b0;
                    end
                end
                LSU_WAIT: begin
                    if (dmem.rvalid) begin
                        state_r <= LSU_IDLE;
                        if (op_load_r && !dropped_r && !flush_i) begin
                            wb_valid_r <= 1'b1;
                            wb_rd_r    <= op_rd_r;
                            wb_data_r  <= fmt_data_s;
                        end
                    end else if (flush_i) begin
                        dropped_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= LSU_IDLE;
                    req_r   <= 1'b0;
                end
            endcase
        end
    end

    assign lsu_busy_o = (state_r != LSU_IDLE);
    assign dmem.req   = req_r;
    assign dmem.we    = we_r;
    assign dmem.be    = be_r;
    assign dmem.addr  = addr_r;
    assign dmem.wdata = wdata_r;
    assign wb_valid_o = wb_valid_r;
    assign wb_rd_o    = wb_rd_r;
    assign wb_data_o  = wb_data_r;
    assign wb_sel_o   = REG_LOAD;
    assign excep_o    = excep_r;

endmodule

// File: tb/tb_orv_lsu.sv
// Directed self-checking bench for orv_lsu with a cycle-driven memory model.
module tb_orv_lsu;
    import orv_lsu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_load;
    logic        ex_store;
    logic [1:0]  ex_len;
    logic        ex_uns;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic [4:0]  ex_rd;
    logic        flush;
    logic        busy;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [2:0]  wb_sel;
    logic [1:0]  excep;

    int total;
    int bad;

    orv_lsu_if dmem_if ();

    orv_lsu dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid_i    (ex_valid),
        .ex_load_i     (ex_load),
        .ex_store_i    (ex_store),
        .ex_len_i      (ex_len),
        .ex_unsigned_i (ex_uns),
        .ex_addr_i     (ex_addr),
        .ex_wdata_i    (ex_wdata),
        .ex_rd_i       (ex_rd),
        .flush_i       (flush),
        .lsu_busy_o    (busy),
        .dmem          (dmem_if),
        .wb_valid_o    (wb_valid),
        .wb_rd_o       (wb_rd),
        .wb_data_o     (wb_data),
        .wb_sel_o      (wb_sel),
        .excep_o       (excep)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic ld, input logic st, input logic [1:0] len,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] rd);
        ex_valid = 1'b1;
        ex_load  = ld;
        ex_store = st;
        ex_len   = len;
        ex_uns   = uns;
        ex_addr  = addr;
        ex_wdata = wd;
        ex_rd    = rd;
    endtask

    // Full op: accept, gd cycles without grant, grant, rvd cycles, response.
    task automatic run_op(input string tag, input logic ld, input logic st,
                          input logic [1:0] len, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rdata, input logic [4:0] rd,
                          input int gd, input int rvd, input logic hold,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input logic [31:0] exp_wb);
        set_op(ld, st, len, uns, addr, wd, rd);
        dmem_if.gnt = 1'b0;
        tick();
        if (!hold) ex_valid = 1'b0;
        check_eq({tag, " req"}, {31'd0, dmem_if.req}, 32'd1);
        check_eq({tag, " busy"}, {31'd0, busy}, 32'd1);
        check_eq({tag, " we"}, {31'd0, dmem_if.we}, {31'd0, st});
        check_eq({tag, " addr"}, dmem_if.addr, exp_addr);
        check_eq({tag, " be"}, {28'd0, dmem_if.be}, {28'd0, exp_be});
        if (st) check_eq({tag, " wdata"}, dmem_if.wdata, exp_wd);
        for (int i = 0; i < gd; i++) begin
            tick();
            check_eq({tag, " req held"}, {31'd0, dmem_if.req}, 32'd1);
            check_eq({tag, " addr held"}, dmem_if.addr, exp_addr);
            check_eq({tag, " be held"}, {28'd0, dmem_if.be}, {28'd0, exp_be});
            if (st) check_eq({tag, " wdata held"}, dmem_if.wdata, exp_wd);
        end
        dmem_if.gnt = 1'b1;
        tick();
        dmem_if.gnt = 1'b0;
        check_eq({tag, " req drop"}, {31'd0, dmem_if.req}, 32'd0);
        check_eq({tag, " busy wait"}, {31'd0, busy}, 32'd1);
        for (int i = 0; i < rvd; i++) begin
            tick();
            check_eq({tag, " no reissue"}, {31'd0, dmem_if.req}, 32'd0);
            check_eq({tag, " no early wb"}, {31'd0, wb_valid}, 32'd0);
        end
        dmem_if.rvalid = 1'b1;
        dmem_if.rdata  = rdata;
        tick();
        dmem_if.rvalid = 1'b0;
        dmem_if.rdata  = 32'h0000_0000;
        check_eq({tag, " busy end"}, {31'd0, busy}, 32'd0);
        check_eq({tag, " wb_valid"}, {31'd0, wb_valid}, {31'd0, ld});
        if (ld) begin
            check_eq({tag, " wb_data"}, wb_data, exp_wb);
            check_eq({tag, " wb_rd"}, {27'd0, wb_rd}, {27'd0, rd});
        end
    endtask

    task automatic run_illegal(input string tag, input logic ld, input logic st,
                               input logic [1:0] len, input logic [31:0] addr);
        set_op(ld, st, len, 1'b0, addr, 32'h1234_5678, 5'd3);
        tick();
        ex_valid = 1'b0;
        check_eq({tag, " excep"}, {30'd0, excep}, {30'd0, INST_EXCEP});
        check_eq({tag, " no req"}, {31'd0, dmem_if.req}, 32'd0);
        check_eq({tag, " not busy"}, {31'd0, busy}, 32'd0);
        tick();
        check_eq({tag, " excep clr"}, {30'd0, excep}, {30'd0, NO_EXCEP});
        check_eq({tag, " still no req"}, {31'd0, dmem_if.req}, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic        is_ld;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_len = L8;
        ex_uns = 1'b0; ex_addr = 32'h0; ex_wdata = 32'h0; ex_rd = 5'd0; flush = 1'b0;
        dmem_if.gnt = 1'b0; dmem_if.rvalid = 1'b0; dmem_if.rdata = 32'h0;
        tick();
        tick();
        check_eq("rst req", {31'd0, dmem_if.req}, 32'd0);
        check_eq("rst busy", {31'd0, busy}, 32'd0);
        check_eq("rst be", {28'd0, dmem_if.be}, 32'd0);
        check_eq("rst addr", dmem_if.addr, 32'd0);
        check_eq("rst wb_valid", {31'd0, wb_valid}, 32'd0);
        check_eq("rst wb_data", wb_data, 32'd0);
        check_eq("rst excep", {30'd0, excep}, {30'd0, NO_EXCEP});
        check_eq("rst wb_sel", {29'd0, wb_sel}, {29'd0, REG_LOAD});
        rst_n = 1'b1;
        tick();

        // 1: aligned LW, best-case latency
        run_op("lw", 1'b1, 1'b0, L32, 1'b0, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 5'd7,
               0, 0, 1'b0, 32'h0000_0104, 4'b1111, 32'h0, 32'hDEAD_BEEF);
        tick();
        check_eq("lw wb pulse", {31'd0, wb_valid}, 32'd0);

        // 2: LB / LBU on the top byte
        run_op("lb", 1'b1, 1'b0, L8, 1'b0, 32'h0000_0103, 32'h0, 32'h8011_2233, 5'd9,
               1, 1, 1'b0, 32'h0000_0100, 4'b1000, 32'h0, 32'hFFFF_FF80);
        run_op("lbu", 1'b1, 1'b0, L8, 1'b1, 32'h0000_0103, 32'h0, 32'h8011_2233, 5'd10,
               0, 2, 1'b0, 32'h0000_0100, 4'b1000, 32'h0, 32'h0000_0080);
        run_op("lh", 1'b1, 1'b0, L16, 1'b0, 32'h0000_0302, 32'h0, 32'h9ABC_1234, 5'd11,
               0, 0, 1'b0, 32'h0000_0300, 4'b1100, 32'h0, 32'hFFFF_9ABC);
        run_op("lhu", 1'b1, 1'b0, L16, 1'b1, 32'h0000_0300, 32'h0, 32'h1234_F00D, 5'd12,
               0, 0, 1'b0, 32'h0000_0300, 4'b0011, 32'h0, 32'h0000_F00D);

        // 3: SH with delayed grant, and an SB on byte 1
        run_op("sh", 1'b0, 1'b1, L16, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 5'd0,
               3, 1, 1'b0, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 32'h0);
        run_op("sb", 1'b0, 1'b1, L8, 1'b0, 32'h0000_0401, 32'h1122_3344, 32'h0, 5'd0,
               0, 0, 1'b0, 32'h0000_0400, 4'b0010, 32'h4444_4444, 32'h0);

        // 4: illegal accesses
        run_illegal("ill lw", 1'b1, 1'b0, L32, 32'h0000_0101);
        run_illegal("ill sh", 1'b0, 1'b1, L16, 32'h0000_0203);
        run_illegal("ill len", 1'b1, 1'b0, L_ILL, 32'h0000_0100);
        run_illegal("ill ldst", 1'b1, 1'b1, L32, 32'h0000_0100);

        // 5a: flush in IDLE blocks acceptance
        set_op(1'b1, 1'b0, L32, 1'b0, 32'h0000_0500, 32'h0, 5'd4);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        ex_valid = 1'b0;
        check_eq("flush idle req", {31'd0, dmem_if.req}, 32'd0);
        check_eq("flush idle busy", {31'd0, busy}, 32'd0);

        // 5b: flush in REQ before grant
        set_op(1'b1, 1'b0, L32, 1'b0, 32'h0000_0500, 32'h0, 5'd4);
        tick();
        ex_valid = 1'b0;
        check_eq("flush req pre", {31'd0, dmem_if.req}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("flush req drop", {31'd0, dmem_if.req}, 32'd0);
        check_eq("flush req idle", {31'd0, busy}, 32'd0);

        // 5c: flush in WAIT, response consumed without writeback
        set_op(1'b1, 1'b0, L32, 1'b0, 32'h0000_0600, 32'h0, 5'd5);
        dmem_if.gnt = 1'b1;
        tick();
        ex_valid = 1'b0;
        tick();
        dmem_if.gnt = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("flush wait busy", {31'd0, busy}, 32'd1);
        dmem_if.rvalid = 1'b1;
        dmem_if.rdata  = 32'hCAFE_F00D;
        tick();
        dmem_if.rvalid = 1'b0;
        check_eq("flush wait wb", {31'd0, wb_valid}, 32'd0);
        check_eq("flush wait idle", {31'd0, busy}, 32'd0);
        tick();
        check_eq("flush wait wb2", {31'd0, wb_valid}, 32'd0);

        // 6: back-to-back LW/SW with ex_valid held and random delays
        for (int n = 0; n < 12; n++) begin
            a     = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            d     = $urandom;
            is_ld = (n % 2 == 0);
            run_op(is_ld ? "b2b lw" : "b2b sw", is_ld, ~is_ld, L32, 1'b0, a, d, d,
                   5'(n + 1), $urandom_range(0, 4), $urandom_range(0, 4), 1'b1,
                   a, 4'b1111, d, d);
        end
        ex_valid = 1'b0;
        tick();
        check_eq("b2b idle", {31'd0, busy}, 32'd0);

        // Reset asserted mid-operation
        set_op(1'b0, 1'b1, L32, 1'b0, 32'h0000_0700, 32'h5555_AAAA, 5'd0);
        tick();
        ex_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("midrst req", {31'd0, dmem_if.req}, 32'd0);
        check_eq("midrst busy", {31'd0, busy}, 32'd0);
        check_eq("midrst wb_sel", {29'd0, wb_sel}, {29'd0, REG_LOAD});
        tick();
        rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
